sample_router: RTL and testbench

SAMPLE_ROUTER -- requirements
Module: sample_router

---
 rtl/sample_router_pkg.sv | 26 ++
 rtl/router_chan.sv | 127 ++++++++++++
 rtl/sample_router.sv | 77 +++++++
 tb/tb_sample_router.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sample_router_pkg.sv
// Shared types for the sample router: output modes and per-channel crossfade states.
// Pure declarations; no timing or flow control of its own.
package sample_router_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_MUTE  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FADE_IN  = 2'd2
  } chan_state_e;

  // The reserved encoding 3 behaves exactly like MUTE.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd0:    return MODE_PASS;
      2'd1:    return MODE_CONST;
      default: return MODE_MUTE;
    endcase
  endfunction

endpackage

// File: rtl/router_chan.sv
// One output channel: source select, gain ramp FSM and scaling multiply; output updates on the tick cycle.
// A load is taken only while idle (the top gates it); ticks are never stalled.
module router_chan
  import sample_router_pkg::*;
#(
  parameter int W         = 16,
  parameter int N         = 4,
  parameter int RAMP_LOG2 = 6,
  parameter int CH        = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   load,
  input  logic [1:0]             cfg_mode,
  input  logic [$clog2(N)-1:0]   cfg_src,
  input  logic [W-1:0]           cfg_const,
  input  logic [N*W-1:0]         sample_in,
  input  logic [7:0]             jack,
  output logic [W-1:0]           sample_out,
  output logic                   busy
);

  localparam int SW = $clog2(N);
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = W + GW + 1;
  localparam logic [GW-1:0] G_MAX = {1'b1, {RAMP_LOG2{1'b0}}};

  chan_state_e         state_q, state_d;
  logic [GW-1:0]       g_q, g_d;
  mode_e               act_mode_q, act_mode_d, pend_mode_q, pend_mode_d;
  logic [SW-1:0]       act_src_q, act_src_d, pend_src_q, pend_src_d;
  logic [W-1:0]        act_const_q, act_const_d, pend_const_q, pend_const_d;
  logic signed [W-1:0] out_q, out_d;

  logic signed [W-1:0]  src_val;
  logic signed [PW-1:0] src_ext, g_ext, prod;
  logic                 jack_bit;

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    act_mode_d   = act_mode_q;
    act_src_d    = act_src_q;
    act_const_d  = act_const_q;
    pend_mode_d  = pend_mode_q;
    pend_src_d   = pend_src_q;
    pend_const_d = pend_const_q;
    out_d        = out_q;
    src_val      = '0;

    // Source uses the active config as it stands before any swap on this edge.
    jack_bit = |(jack & (8'd1 << act_src_q));
    case (act_mode_q)
      MODE_PASS: begin
        if ((32'(act_src_q) < 32'(N)) && jack_bit)
          src_val = W'(sample_in >> (act_src_q * W));
      end
      MODE_CONST: src_val = act_const_q;
      default:    src_val = '0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pend_mode_d  = decode_mode(cfg_mode);
          pend_src_d   = cfg_src;
          pend_const_d = cfg_const;
          state_d      = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        if (tick) begin
          g_d = g_q - 1'b1;
          if (g_d == '0) begin
            act_mode_d  = pend_mode_q;
            act_src_d   = pend_src_q;
            act_const_d = pend_const_q;
            state_d     = ST_FADE_IN;
          end
        end
      end
      default: begin
        if (tick) begin
          g_d = g_q + 1'b1;
          if (g_d == G_MAX)
            state_d = ST_IDLE;
        end
      end
    endcase

    // Gain never exceeds 2^RAMP_LOG2, so the shifted product always fits in W bits.
    src_ext = PW'(src_val);
    g_ext   = PW'($signed({1'b0, g_d}));
    prod    = src_ext * g_ext;
    if (tick)
      out_d = (state_q == ST_IDLE) ? src_val : W'(prod >>> RAMP_LOG2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      g_q          <= G_MAX;
      act_mode_q   <= MODE_PASS;
      act_src_q    <= SW'(CH);
      act_const_q  <= '0;
      pend_mode_q  <= MODE_PASS;
      pend_src_q   <= '0;
      pend_const_q <= '0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      act_mode_q   <= act_mode_d;
      act_src_q    <= act_src_d;
      act_const_q  <= act_const_d;
      pend_mode_q  <= pend_mode_d;
      pend_src_q   <= pend_src_d;
      pend_const_q <= pend_const_d;
      out_q        <= out_d;
    end
  end

  assign sample_out = out_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/sample_router.sv
// N-channel sample router with click-free crossfade on reconfiguration; outputs lag a sample_clk rise by 2 clk.
// cfg_ready drops while any channel fades; requests made then are dropped, not queued.
module sample_router
  import sample_router_pkg::*;
#(
  parameter int W         = 16,
  parameter int N         = 4,
  parameter int RAMP_LOG2 = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_clk,
  input  logic [N*W-1:0]       sample_in,
  input  logic [7:0]           jack,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [$clog2(N)-1:0] cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [$clog2(N)-1:0] cfg_src,
  input  logic [W-1:0]         cfg_const,
  output logic [N*W-1:0]       sample_out,
  output logic                 busy
);

  localparam int SW = $clog2(N);

  logic         sclk_prev_q, sclk_prev_d;
  logic         tick_q, tick_d;
  logic         ready_q, ready_d;
  logic [N-1:0] busy_vec;
  logic         xfer;

  // Previous-value register resets high so a strobe already high at release is not a tick.
  always_comb begin
    sclk_prev_d = sample_clk;
    tick_d      = sample_clk & ~sclk_prev_q;
    ready_d     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_prev_q <= 1'b1;
      tick_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      tick_q      <= tick_d;
      ready_q     <= ready_d;
    end
  end

  assign busy      = |busy_vec;
  assign cfg_ready = ready_q & ~busy;
  assign xfer      = cfg_valid & cfg_ready;

  for (genvar i = 0; i < N; i++) begin : g_chan
    router_chan #(
      .W         (W),
      .N         (N),
      .RAMP_LOG2 (RAMP_LOG2),
      .CH        (i)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick_q),
      .load       (xfer && (cfg_ch == SW'(i))),
      .cfg_mode   (cfg_mode),
      .cfg_src    (cfg_src),
      .cfg_const  (cfg_const),
      .sample_in  (sample_in),
      .jack       (jack),
      .sample_out (sample_out[i*W +: W]),
      .busy       (busy_vec[i])
    );
  end

endmodule

// File: tb/tb_sample_router.sv
// Directed bench for sample_router at W=16, N=4, RAMP_LOG2=2 with hand-computed expectations.
module tb_sample_router;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_clk = 1'b1;
  logic [63:0] sample_in;
  logic [7:0]  jack = 8'hFF;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [1:0]  cfg_src = '0;
  logic [15:0] cfg_const = '0;
  logic [63:0] sample_out;
  logic        busy;

  logic signed [15:0] in_v [4];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    sample_in = '0;
    for (int i = 0; i < 4; i++) sample_in[i*16 +: 16] = in_v[i];
  end

  sample_router #(.W(16), .N(4), .RAMP_LOG2(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .sample_in  (sample_in),
    .jack       (jack),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_src    (cfg_src),
    .cfg_const  (cfg_const),
    .sample_out (sample_out),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] out_ch(input int c);
    logic signed [15:0] v;
    v = sample_out[c*16 +: 16];
    return 32'(v);
  endfunction

  // Rise at a negedge; outputs are settled at the second following negedge.
  task automatic do_tick();
    @(negedge clk) sample_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sample_clk = 1'b0;
  endtask

  task automatic send_cfg(input logic [1:0] ch, input logic [1:0] mode,
                          input logic [1:0] src, input logic [15:0] k);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_src = src; cfg_const = k;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  int exp_fade1 [8] = '{600, 400, 200, 0, 1000, 2000, 3000, 4000};
  int exp_fade0 [8] = '{-24576, -16384, -8192, 0, -8192, -16384, -24576, -32768};

  initial begin
    in_v[0] = 16'sd1000; in_v[1] = -16'sd200; in_v[2] = 16'sd3000; in_v[3] = -16'sd7;

    // Reset state
    #22;
    for (int c = 0; c < 4; c++) chk($sformatf("rst_out%0d", c), out_ch(c), 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);

    // Release with sample_clk already high: no tick expected
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", cfg_ready, 1);
    repeat (2) @(negedge clk);
    chk("no_tick_at_release", out_ch(0), 0);
    sample_clk = 1'b0;

    // First tick with exact 2-clk latency
    @(negedge clk) sample_clk = 1'b1;
    @(negedge clk);
    chk("lat_1clk", out_ch(0), 0);
    @(negedge clk);
    chk("lat_2clk_out0", out_ch(0), 1000);
    chk("pass_out1", out_ch(1), -200);
    chk("pass_out2", out_ch(2), 3000);
    chk("pass_out3", out_ch(3), -7);
    sample_clk = 1'b0;

    // Unpatched jack forces the source to zero
    jack = 8'hFB; in_v[2] = 16'sd5000; in_v[1] = 16'sd800;
    do_tick();
    chk("jack_off_out2", out_ch(2), 0);
    chk("jack_on_out1", out_ch(1), 800);
    jack = 8'hFF;

    // Crossfade ch1 to CONST 4000
    send_cfg(2'd1, 2'd1, 2'd0, 16'd4000);
    chk("fade1_busy_start", busy, 1);
    chk("fade1_ready_low", cfg_ready, 0);
    chk("fade1_hold", out_ch(1), 800);
    for (int k = 0; k < 8; k++) begin
      do_tick();
      chk($sformatf("fade1_t%0d", k + 1), out_ch(1), exp_fade1[k]);
      chk($sformatf("fade1_busy_t%0d", k + 1), busy, (k < 7) ? 1 : 0);
      if (k == 0) begin
        in_v[0] = 16'sd1234;
        @(negedge clk);
        chk("between_ticks_out0", out_ch(0), 1000);
      end
      if (k == 1) begin
        chk("out0_new_sample", out_ch(0), 1234);
        chk("busy_ready_low", cfg_ready, 0);
        send_cfg(2'd1, 2'd2, 2'd0, 16'd0);
      end
    end
    chk("fade1_ready_back", cfg_ready, 1);

    // Same-config fade of full-scale negative input
    in_v[0] = -16'sd32768;
    send_cfg(2'd0, 2'd0, 2'd0, 16'd0);
    for (int k = 0; k < 8; k++) begin
      do_tick();
      chk($sformatf("fade0_t%0d", k + 1), out_ch(0), exp_fade0[k]);
    end
    chk("fade0_busy_end", busy, 0);

    // Tick coinciding with a transfer applies to the old state
    @(negedge clk) sample_clk = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'd0; cfg_src = 2'd1; cfg_const = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0; sample_clk = 1'b0;
    chk("coincide_out1", out_ch(1), 4000);
    chk("coincide_busy", busy, 1);
    do_tick();
    chk("coincide_t1", out_ch(1), 3000);
    do_tick();
    chk("coincide_t2", out_ch(1), 2000);

    // Asynchronous reset mid-fade
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) chk($sformatf("arst_out%0d", c), out_ch(c), 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    do_tick();
    chk("post_rst_out1", out_ch(1), 800);
    chk("post_rst_out0", out_ch(0), -32768);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
